// File: rtl/demux14_buf_pkg.sv
// demux14_buf_pkg: channel encodings and sizing shared by the demux14_buf slice
package demux14_buf_pkg;
    localparam int CH_SEL_W = 2;
    localparam int NUM_CH = 4;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [CH_SEL_W-1:0] {CH_WB, CH_MEM, CH_BR, CH_DBG} ch_e;
endpackage

// File: rtl/demux14_buf_if.sv
// demux14_buf_if: select-tagged input port plus four packed output queue ports
interface demux14_buf_if import demux14_buf_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
    logic                      in_valid;
    logic                      in_ready;
    logic [CH_SEL_W-1:0]       in_sel;
    logic [WIDTH-1:0]          in_data;
    logic [NUM_CH-1:0]         out_valid;
    logic [NUM_CH-1:0]         out_ready;
    logic [NUM_CH*WIDTH-1:0]   out_data;
    logic                      busy;
    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/demux14_buf_chan_fifo2.sv
// chan_fifo2: 2-entry synchronous FIFO with 1-bit pointers, gated push/pop
module chan_fifo2 import demux14_buf_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       cnt;
    logic             do_push, do_pop;
    assign full = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    // pop on empty and push on full are dropped so count never wraps
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign head_data = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop)
                rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/demux14_buf.sv
// demux14_buf: 1-to-4 demux steering each input word into a per-channel 2-entry queue
module demux14_buf import demux14_buf_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
    input logic          clk,
    input logic          rst_n,
    demux14_buf_if.slave bus
);
    logic [NUM_CH-1:0]       push, full, empty;
    logic [WIDTH-1:0]        head [NUM_CH];
    logic [NUM_CH*WIDTH-1:0] packed_data;
    // ready comes from registered fullness only, never from out_ready
    assign bus.in_ready = !full[bus.in_sel];
    assign bus.out_valid = ~empty;
    assign bus.busy = |(~empty);
    assign bus.out_data = packed_data;
    always_comb begin
        push = '0;
        packed_data = '0;
        if (bus.in_valid && bus.in_ready)
            push[bus.in_sel] = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            packed_data[i*WIDTH +: WIDTH] = head[i];
    end
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        chan_fifo2 #(.WIDTH(WIDTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[k]),
            .push_data (bus.in_data),
            .pop       (bus.out_ready[k]),
            .head_data (head[k]),
            .full      (full[k]),
            .empty     (empty[k])
        );
    end
endmodule

// File: doc/demux14_buf.md
Name: demux14_buf

Overview:
- 1-to-4 demultiplexer for the 32-bit datapath, the distribution counterpart of the operand/result selectors.
- Accepts one word per cycle on a valid/ready input, tagged with a 2-bit destination select.
- Steers each word into one of four independent 2-entry output queues, each drained through its own valid/ready port.
- Sits between an execute/result source and up to four consumers: writeback, store path, branch unit, debug tap.

Parameters:
- WIDTH, 32, data width of every channel.
- DEPTH, 2, entries per channel queue; fixed at 2 in this revision, pointer width 1 bit.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input can be accepted this cycle.
- in_sel  input  2  destination channel 0..3.
- in_data  input  WIDTH  input word.
- out_valid  output  4  bit k: channel k head valid.
- out_ready  input  4  bit k: consumer k takes head this cycle.
- out_data  output  4*WIDTH  channel k head at bits [k*WIDTH +: WIDTH].
- busy  output  1  OR of all channel non-empty flags.

Behaviour:
- Reset (async assert, sync deassert by the integrator): all queue counts = 0, pointers = 0, out_valid = 4'b0000, busy = 0, out_data = 0. Storage contents are don't-care but read as 0 after reset.
- Input handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (count[in_sel] != 2), derived from registered count only. There is no combinational path from out_ready to in_ready.
  - in_ready may depend on in_sel combinationally. Sources must hold in_sel/in_data stable while in_valid && !in_ready.
- Output handshake:
  - Channel k pops when out_valid[k] && out_ready[k].
  - out_valid[k] = (count[k] != 0).
  - out_data slice k = entry at rd_ptr[k]. It is stable while out_valid[k] && !out_ready[k].
- Latency: a word accepted in cycle N appears as channel head (out_valid high) in cycle N+1 if that queue was empty. Otherwise it appears after older entries drain. Per-channel order is strictly FIFO. There is no ordering between channels.
- Count update per channel, each cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop same channel: unchanged, both pointers advance.
  - neither: hold.
- Push into channel k requires in_sel == k and an input transfer. Only one channel can be pushed per cycle.
- Boundaries:
  - Full channel (count 2) blocks input only when in_sel selects it. Words for other channels still flow.
  - Pop of a full channel in cycle N makes in_ready high in cycle N+1, not N.
  - out_ready[k] with count[k] == 0 is ignored: no underflow, pointers hold.
  - in_valid low: in_sel and in_data are ignored.
  - Pointer wrap: 1-bit pointers toggle 1->0 naturally.
- Reset mid-operation: asserting rst_n low discards all queued words immediately (async). out_valid drops in the same instant, and nothing is replayed after release.
- busy = |out_valid, combinational from registered counts.

Decomposition:
- Shared package holds:
  - CH_SEL_W = 2 and NUM_CH = 4.
  - Channel encodings CH_WB = 0, CH_MEM = 1, CH_BR = 2, CH_DBG = 3.
  - Default WIDTH = 32.
- One sub-module, chan_fifo2: a 2-entry synchronous FIFO.
  - Ports: clk, rst_n, push, push_data, pop, head_data, full, empty.
  - Instantiated four times. The top contains only the select decode, in_ready mux, and output packing.

Test Plan:
- After reset release, drive in_valid=0 -> out_valid=4'b0000, busy=0, in_ready=1, out_data=0.
- Single route: in_sel=2, in_data=32'hDEADBEEF for one cycle, all out_ready=0 -> next cycle out_valid=4'b0100, slice 2 = DEADBEEF, other slices unchanged, busy=1.
- Fill and block: send 32'h1, 32'h2, 32'h3 to channel 0 back-to-back with out_ready=0 -> in_ready low on the third word. Then pulse out_ready[0] for one cycle -> head 1 pops, in_ready high the following cycle, 32'h3 accepted. Drained order is 1, 2, 3.
- Independence: channel 1 full, out_ready=0; present in_sel=1 (stalls) and then in_sel=3, data 32'hA5A5A5A5 -> channel 3 receives it and channel 1 contents are unchanged.
- Simultaneous push/pop: channel 0 holds 32'h10, out_ready[0]=1 while pushing 32'h20 to channel 0 -> count stays 1, next head = 32'h20, no loss or duplicate.
- Reset mid-operation: channels 0 and 3 each hold 2 words; assert rst_n low between edges -> out_valid=0 and busy=0 immediately. After release, no old data appears.
